// File: rtl/fxu_pkg.sv
// Shared FXU definitions: opcodes, datapath widths and the reservation-station
// entry record. Also imported by the FXU and the other RS banks.
package fxu_pkg;

  localparam int TAG_W  = 6;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_MOV = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD = 4'd1;
  localparam logic [OP_W-1:0] OP_JEQ = 4'd6;

  typedef enum logic [1:0] {
    FREE,
    WAIT,
    READY,
    ISSUED
  } rs_state_e;

  typedef struct packed {
    rs_state_e          state;
    logic [OP_W-1:0]    op;
    logic               rdy0;
    logic               rdy1;
    logic [TAG_W-1:0]   tag0;
    logic [TAG_W-1:0]   tag1;
    logic [DATA_W-1:0]  val0;
    logic [DATA_W-1:0]  val1;
  } rs_entry_t;

  localparam rs_entry_t RS_ENTRY_RESET = '{
    state: FREE,
    op:    '0,
    rdy0:  1'b0,
    rdy1:  1'b0,
    tag0:  '0,
    tag1:  '0,
    val0:  '0,
    val1:  '0
  };

endpackage

// File: rtl/fxu_rs_if.sv
// Dispatch, CDB and issue signals of one FXU reservation-station bank.
// master: dispatch/CDB/FXU side; slave: the RS bank itself.
interface fxu_rs_if;
  import fxu_pkg::*;

  logic                disp_valid;
  logic [OP_W-1:0]     disp_op;
  logic                disp_rdy0;
  logic                disp_rdy1;
  logic [TAG_W-1:0]    disp_tag0;
  logic [TAG_W-1:0]    disp_tag1;
  logic [DATA_W-1:0]   disp_val0;
  logic [DATA_W-1:0]   disp_val1;
  logic                disp_ready;
  logic [TAG_W-1:0]    disp_rs_num;

  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_rs_num;
  logic [DATA_W-1:0]   cdb_data;

  logic                fxu_busy;
  logic                fxu_valid;
  logic [TAG_W-1:0]    fxu_rs_num;
  logic [OP_W-1:0]     fxu_op;
  logic [DATA_W-1:0]   fxu_val0;
  logic [DATA_W-1:0]   fxu_val1;

  modport master (
    output disp_valid, disp_op, disp_rdy0, disp_rdy1, disp_tag0, disp_tag1,
           disp_val0, disp_val1, cdb_valid, cdb_rs_num, cdb_data, fxu_busy,
    input  disp_ready, disp_rs_num, fxu_valid, fxu_rs_num, fxu_op,
           fxu_val0, fxu_val1
  );

  modport slave (
    input  disp_valid, disp_op, disp_rdy0, disp_rdy1, disp_tag0, disp_tag1,
           disp_val0, disp_val1, cdb_valid, cdb_rs_num, cdb_data, fxu_busy,
    output disp_ready, disp_rs_num, fxu_valid, fxu_rs_num, fxu_op,
           fxu_val0, fxu_val1
  );

endinterface

// File: rtl/fxu_rs_rr_pick.sv
// Round-robin picker: grants the first requester after last_i, wrapping
// from N-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     grant_o,
  output logic             valid_o
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which is what would otherwise infer a latch.
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IDX_W'((int'(last_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fxu_rs.sv
// FXU reservation-station bank: captures operands from the CDB, issues one
// ready entry per cycle round-robin, and holds each tag until its broadcast.
module fxu_rs
  import fxu_pkg::*;
#(
  parameter int NRS     = 4,
  parameter int RS_BASE = 0
) (
  input  logic    clk,
  input  logic    reset,
  fxu_rs_if.slave rs
);

  localparam int IDX_W = $clog2(NRS);

  rs_entry_t         entry_q [NRS];
  rs_entry_t         entry_d [NRS];
  logic [IDX_W-1:0]  last_q, last_d;
  logic              fxu_valid_q, fxu_valid_d;
  logic [TAG_W-1:0]  fxu_rs_num_q, fxu_rs_num_d;
  logic [OP_W-1:0]   fxu_op_q, fxu_op_d;
  logic [DATA_W-1:0] fxu_val0_q, fxu_val0_d;
  logic [DATA_W-1:0] fxu_val1_q, fxu_val1_d;

  logic [NRS-1:0]    free_vec;
  logic [NRS-1:0]    ready_vec;
  logic [NRS-1:0]    grant;
  logic              grant_valid;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  grant_idx;
  logic              disp_fire;
  logic              issue;
  rs_entry_t         sel_entry;

  function automatic logic [TAG_W-1:0] tag_of(input int idx);
    return TAG_W'(RS_BASE + idx);
  endfunction

  rr_pick #(.N(NRS), .IDX_W(IDX_W)) u_pick (
    .req_i   (ready_vec),
    .last_i  (last_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  // Output decode: depends on registered entry state only, never on the CDB.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    free_idx  = '0;
    grant_idx = '0;
    for (int i = NRS - 1; i >= 0; i--) begin
      free_vec[i]  = (entry_q[i].state == FREE);
      ready_vec[i] = (entry_q[i].state == READY);
      if (entry_q[i].state == FREE) free_idx = IDX_W'(i);
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  assign disp_fire = rs.disp_valid && (|free_vec);
  assign issue     = grant_valid && !rs.fxu_busy;
  assign sel_entry = entry_q[grant_idx];

  // Next-state for every entry's FSM.
  always_comb begin
    entry_d = entry_q;
    for (int i = 0; i < NRS; i++) begin
      unique case (entry_q[i].state)
        FREE: begin
          if (disp_fire && free_idx == IDX_W'(i)) begin
            entry_d[i].op   = rs.disp_op;
            entry_d[i].tag0 = rs.disp_tag0;
            entry_d[i].tag1 = rs.disp_tag1;
            entry_d[i].rdy0 = rs.disp_rdy0 ||
                              (rs.cdb_valid && rs.cdb_rs_num == rs.disp_tag0);
            entry_d[i].rdy1 = rs.disp_rdy1 ||
                              (rs.cdb_valid && rs.cdb_rs_num == rs.disp_tag1);
            entry_d[i].val0 = rs.disp_rdy0 ? rs.disp_val0 : rs.cdb_data;
            entry_d[i].val1 = rs.disp_rdy1 ? rs.disp_val1 : rs.cdb_data;
            entry_d[i].state = (entry_d[i].rdy0 && entry_d[i].rdy1) ? READY : WAIT;
          end
        end
        WAIT: begin
          if (!entry_q[i].rdy0 && rs.cdb_valid && rs.cdb_rs_num == entry_q[i].tag0) begin
            entry_d[i].rdy0 = 1'b1;
            entry_d[i].val0 = rs.cdb_data;
          end
          if (!entry_q[i].rdy1 && rs.cdb_valid && rs.cdb_rs_num == entry_q[i].tag1) begin
            entry_d[i].rdy1 = 1'b1;
            entry_d[i].val1 = rs.cdb_data;
          end
          if (entry_d[i].rdy0 && entry_d[i].rdy1) entry_d[i].state = READY;
        end
        READY: begin
          if (issue && grant[i]) entry_d[i].state = ISSUED;
        end
        ISSUED: begin
          if (rs.cdb_valid && rs.cdb_rs_num == tag_of(i)) entry_d[i].state = FREE;
        end
      endcase
    end
  end

  // Issue register next-state: payload holds its last value when idle.
  always_comb begin
    last_d       = last_q;
    fxu_valid_d  = issue;
    fxu_rs_num_d = fxu_rs_num_q;
    fxu_op_d     = fxu_op_q;
    fxu_val0_d   = fxu_val0_q;
    fxu_val1_d   = fxu_val1_q;
    if (issue) begin
      last_d       = grant_idx;
      fxu_rs_num_d = tag_of(int'(grant_idx));
      fxu_op_d     = sel_entry.op;
      fxu_val0_d   = sel_entry.val0;
      fxu_val1_d   = sel_entry.val1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the whole entry array is reset, not just the state field, so the
      // issue mux never forwards X payload from a never-written entry.
      for (int i = 0; i < NRS; i++) entry_q[i] <= RS_ENTRY_RESET;
      last_q       <= '0;
      fxu_valid_q  <= 1'b0;
      fxu_rs_num_q <= '0;
      fxu_op_q     <= '0;
      fxu_val0_q   <= '0;
      fxu_val1_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      entry_q      <= entry_d;
      last_q       <= last_d;
      fxu_valid_q  <= fxu_valid_d;
      fxu_rs_num_q <= fxu_rs_num_d;
      fxu_op_q     <= fxu_op_d;
      fxu_val0_q   <= fxu_val0_d;
      fxu_val1_q   <= fxu_val1_d;
    end
  end

  assign rs.disp_ready  = |free_vec;
  assign rs.disp_rs_num = tag_of(int'(free_idx));
  assign rs.fxu_valid   = fxu_valid_q;
  assign rs.fxu_rs_num  = fxu_rs_num_q;
  assign rs.fxu_op      = fxu_op_q;
  assign rs.fxu_val0    = fxu_val0_q;
  assign rs.fxu_val1    = fxu_val1_q;

endmodule

// File: tb/tb_fxu_rs.sv
// Directed bench for fxu_rs (NRS=4, RS_BASE=0): dispatch, CDB capture and
// bypass, round-robin issue with wrap, release/reuse and mid-run reset.
module tb_fxu_rs;
  import fxu_pkg::*;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  fxu_rs_if rs_if ();

  fxu_rs #(.NRS(4), .RS_BASE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rs_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_if.disp_valid = 1'b0;
    rs_if.cdb_valid  = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op,
                      input logic r0, input logic [5:0] t0, input logic [15:0] v0,
                      input logic r1, input logic [5:0] t1, input logic [15:0] v1);
    rs_if.disp_valid = 1'b1;
    rs_if.disp_op    = op;
    rs_if.disp_rdy0  = r0;
    rs_if.disp_tag0  = t0;
    rs_if.disp_val0  = v0;
    rs_if.disp_rdy1  = r1;
    rs_if.disp_tag1  = t1;
    rs_if.disp_val1  = v1;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [15:0] data);
    rs_if.cdb_valid  = 1'b1;
    rs_if.cdb_rs_num = tag;
    rs_if.cdb_data   = data;
  endtask

  task automatic check_issue(input string tag, input logic [5:0] num,
                             input logic [3:0] op, input logic [15:0] v0,
                             input logic [15:0] v1);
    check({tag, "_valid"}, rs_if.fxu_valid, 1);
    check({tag, "_rs_num"}, rs_if.fxu_rs_num, num);
    check({tag, "_op"}, rs_if.fxu_op, op);
    check({tag, "_val0"}, rs_if.fxu_val0, v0);
    check({tag, "_val1"}, rs_if.fxu_val1, v1);
  endtask

  initial begin
    reset = 1'b1;
    rs_if.fxu_busy = 1'b0;
    disp(OP_MOV, 0, 0, 0, 0, 0, 0);
    cdb(0, 0);
    idle();
    #12;
    check("rst_disp_ready", rs_if.disp_ready, 1);
    check("rst_disp_rs_num", rs_if.disp_rs_num, 0);
    check("rst_fxu_valid", rs_if.fxu_valid, 0);
    #10 reset = 1'b0;
    tick();

    // ADD with both operands ready: issues two edges after dispatch.
    disp(OP_ADD, 1, 0, 16'd3, 1, 0, 16'd4);
    check("add_disp_rs_num", rs_if.disp_rs_num, 0);
    tick(); idle();
    check("add_no_issue_e0", rs_if.fxu_valid, 0);
    tick();
    check_issue("add_issue", 0, OP_ADD, 16'd3, 16'd4);
    tick();
    check("add_valid_one_cycle", rs_if.fxu_valid, 0);
    check("add_op_held", rs_if.fxu_op, OP_ADD);
    check("add_entry_held", rs_if.disp_rs_num, 1);
    cdb(0, 16'h0007); tick(); idle();
    check("add_released", rs_if.disp_rs_num, 0);

    // MOV waiting on tag 9; unrelated tag 8 must not wake it.
    disp(OP_MOV, 0, 6'd9, 0, 1, 0, 16'h0055);
    tick(); idle();
    check("mov_wait", rs_if.fxu_valid, 0);
    cdb(6'd8, 16'h5555); tick(); idle();
    check("mov_tag8_a", rs_if.fxu_valid, 0);
    tick();
    check("mov_tag8_b", rs_if.fxu_valid, 0);
    cdb(6'd9, 16'h1234); tick(); idle();
    check("mov_capture_edge", rs_if.fxu_valid, 0);
    tick();
    check_issue("mov_issue", 0, OP_MOV, 16'h1234, 16'h0055);
    cdb(0, 16'h0000); tick(); idle();
    check("mov_released", rs_if.disp_rs_num, 0);

    // Dispatch/CDB bypass on operand 1.
    disp(OP_ADD, 1, 0, 16'd7, 0, 6'd5, 0);
    cdb(6'd5, 16'h00AA);
    tick(); idle();
    check("byp_e0", rs_if.fxu_valid, 0);
    tick();
    check_issue("byp_issue", 0, OP_ADD, 16'd7, 16'h00AA);

    // Release of ISSUED entry 0 in the same cycle as a dispatch.
    cdb(0, 16'h0001);
    disp(OP_ADD, 0, 6'd40, 0, 1, 0, 16'h0101);
    check("rel_disp_other", rs_if.disp_rs_num, 1);
    tick(); idle();
    check("rel_no_issue", rs_if.fxu_valid, 0);
    check("rel_reuse_num", rs_if.disp_rs_num, 0);
    disp(OP_ADD, 0, 6'd40, 0, 1, 0, 16'h0100);
    tick(); idle();
    check("rel_next_free", rs_if.disp_rs_num, 2);
    disp(OP_ADD, 0, 6'd40, 0, 1, 0, 16'h0102);
    tick(); idle();
    check("fill_next_free", rs_if.disp_rs_num, 3);
    disp(OP_ADD, 1, 0, 16'h0011, 1, 0, 16'h0022);
    tick(); idle();
    check("full_ready_low", rs_if.disp_ready, 0);
    tick();
    check_issue("e3_issue", 3, OP_ADD, 16'h0011, 16'h0022);

    // Full bank ignores dispatch.
    disp(OP_JEQ, 1, 0, 16'hFFFF, 1, 0, 16'hFFFF);
    tick(); idle();
    check("full_ignored_ready", rs_if.disp_ready, 0);
    check("full_ignored_valid", rs_if.fxu_valid, 0);

    // One broadcast wakes entries 0..2; refill entry 3 while the FXU is busy.
    rs_if.fxu_busy = 1'b1;
    cdb(6'd40, 16'hBEEF); tick(); idle();
    check("busy_no_issue_a", rs_if.fxu_valid, 0);
    cdb(6'd3, 16'h0000); tick(); idle();
    check("e3_released_ready", rs_if.disp_ready, 1);
    check("e3_released_num", rs_if.disp_rs_num, 3);
    disp(OP_MOV, 1, 0, 16'h3333, 1, 0, 16'h0003);
    tick(); idle();
    check("busy_full", rs_if.disp_ready, 0);
    tick();
    check("busy_no_issue_b", rs_if.fxu_valid, 0);
    rs_if.fxu_busy = 1'b0;
    tick();
    check_issue("rr0", 0, OP_ADD, 16'hBEEF, 16'h0100);
    tick();
    check_issue("rr1", 1, OP_ADD, 16'hBEEF, 16'h0101);
    tick();
    check_issue("rr2", 2, OP_ADD, 16'hBEEF, 16'h0102);
    tick();
    check_issue("rr3", 3, OP_MOV, 16'h3333, 16'h0003);
    tick();
    check("rr_drained", rs_if.fxu_valid, 0);

    // Wrap from index 3: entries 0 and 2 both ready, 0 goes first.
    cdb(6'd2, 16'h0000); tick();
    cdb(6'd0, 16'h0000); tick(); idle();
    check("wrap_free0", rs_if.disp_rs_num, 0);
    rs_if.fxu_busy = 1'b1;
    disp(OP_ADD, 1, 0, 16'h00C0, 1, 0, 16'h00C1);
    tick();
    check("wrap_free2", rs_if.disp_rs_num, 2);
    disp(OP_ADD, 1, 0, 16'h00C2, 1, 0, 16'h00C3);
    tick(); idle();
    rs_if.fxu_busy = 1'b0;
    check("wrap_busy_idle", rs_if.fxu_valid, 0);
    tick();
    check_issue("wrap_first", 0, OP_ADD, 16'h00C0, 16'h00C1);
    tick();
    check_issue("wrap_second", 2, OP_ADD, 16'h00C2, 16'h00C3);

    // Mix of WAIT/READY/ISSUED entries, then asynchronous reset.
    cdb(6'd1, 16'h0000); tick();
    cdb(6'd2, 16'h0000); tick(); idle();
    rs_if.fxu_busy = 1'b1;
    check("mix_free1", rs_if.disp_rs_num, 1);
    disp(OP_ADD, 0, 6'd50, 0, 1, 0, 16'h0111);
    tick();
    check("mix_free2", rs_if.disp_rs_num, 2);
    disp(OP_JEQ, 1, 0, 16'h0202, 1, 0, 16'h0203);
    tick(); idle();
    check("mix_full", rs_if.disp_ready, 0);
    check("mix_val0_held", rs_if.fxu_val0, 16'h00C2);
    #3 reset = 1'b1;
    #1;
    check("arst_valid", rs_if.fxu_valid, 0);
    check("arst_rs_num", rs_if.fxu_rs_num, 0);
    check("arst_op", rs_if.fxu_op, 0);
    check("arst_val0", rs_if.fxu_val0, 0);
    check("arst_val1", rs_if.fxu_val1, 0);
    check("arst_disp_ready", rs_if.disp_ready, 1);
    check("arst_disp_rs_num", rs_if.disp_rs_num, 0);
    #2 reset = 1'b0;
    rs_if.fxu_busy = 1'b0;
    tick();
    disp(OP_ADD, 1, 0, 16'h000A, 1, 0, 16'h000B);
    check("post_rst_rs_num", rs_if.disp_rs_num, 0);
    tick(); idle();
    check("post_rst_e0", rs_if.fxu_valid, 0);
    tick();
    check_issue("post_rst_issue", 0, OP_ADD, 16'h000A, 16'h000B);
    tick();
    check("post_rst_idle", rs_if.fxu_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fxu_rs.md
# fxu_rs

Reservation-station bank and issue scheduler for the single FXU in the Tomasulo core. Accepts dispatched MOV/ADD/JEQ operations with operand values or producer tags, and captures missing operands from the common data bus (CDB). Each cycle it selects one ready entry round-robin and issues it to the FXU. Each entry holds its tag until that tag's result is broadcast on the CDB, so tags never alias.

## Interface
- NRS, 4: number of entries, 2..16.
- RS_BASE, 0: tag of entry 0. Entry i owns tag RS_BASE+i.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- disp_valid  in  1  dispatch request; accepted only when disp_ready=1.
- disp_op  in  4  opcode: MOV=0, ADD=1, JEQ=6.
- disp_rdy0 / disp_rdy1  in  1  operand 0 / operand 1 value present.
- disp_tag0 / disp_tag1  in  6  producer tag, used when the matching rdy bit is 0.
- disp_val0 / disp_val1  in  16  operand value, used when the matching rdy bit is 1.
- disp_ready  out  1  at least one entry is FREE.
- disp_rs_num  out  6  tag that will be assigned to the dispatch; valid while disp_ready=1.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_rs_num  in  6  tag of the producer on the CDB.
- cdb_data  in  16  broadcast result.
- fxu_busy  in  1  FXU cannot accept an issue this cycle.
- fxu_valid  out  1  issue strobe, one cycle per op.
- fxu_rs_num  out  6  tag of the issued entry.
- fxu_op  out  4  opcode.
- fxu_val0 / fxu_val1  out  16  operand values.

## Operation
- Per-entry state: FREE → WAIT → READY → ISSUED → FREE. Each entry also stores op, rdy0/1, tag0/1 and val0/1.
- Dispatch goes to the lowest-index FREE entry. disp_rs_num = RS_BASE + that index.
  - If both operands are present, the entry enters READY; otherwise it enters WAIT.
- Dispatch/CDB bypass: in the dispatch cycle, cdb_valid with cdb_rs_num equal to a pending disp_tagN captures cdb_data into operand N.
- WAIT entries compare cdb_rs_num against each pending tag every cycle.
  - One broadcast can fill both operands.
  - When the last operand is captured, the entry moves to READY.
- The CDB never modifies operands of READY or ISSUED entries.
- Issue selection:
  - Candidates are entries in READY at the start of the cycle.
  - Search is round-robin, starting at the index after the last issued entry.
  - No issue occurs when fxu_busy=1 or when there is no candidate.
  - The issued entry moves to ISSUED, and the pointer advances to it.
- Release: an ISSUED entry with cdb_valid and cdb_rs_num equal to its own tag returns to FREE. This applies to all ops, including JEQ, whose result is the taken bit.
- A CDB tag matching an entry in FREE, WAIT or READY is not a release.
- Operand arithmetic is not done here. Values pass through unmodified, 16 bits.
- Reset, asynchronous and legal at any time, including mid-operation:
  - All entries become FREE, the pointer becomes 0, and fxu_* outputs become 0.
  - disp_ready becomes 1 combinationally from the FREE states.

## Timing
- disp_ready and disp_rs_num are combinational from entry state only. They do not depend on disp_valid or the CDB.
- fxu_* outputs are registered.
  - Dispatch with both operands ready, sampled at edge E0: the entry is READY after E0 and is selected in the following cycle.
  - fxu_valid is high for the cycle after E1, where E1 is the next edge after E0. Latency is 2 edges.
- Operand captured from the CDB at edge E: issue at edge E+1 at the earliest.
- fxu_valid is high for exactly one cycle per issue. It is 0 on cycles with no issue, and the other fxu_* outputs then hold their last values.
- A release at edge E makes the entry visible as FREE after E. It is not reusable in the same cycle as its own broadcast.
- Full bank: disp_ready=0. disp_valid is ignored and no state changes.
- Round-robin wrap: after index NRS-1, the search continues from index 0.

## Structure
- Shared fxu_pkg: opcode constants (MOV=0, ADD=1, JEQ=6), TAG_W=6, DATA_W=16, and the entry state enum {FREE, WAIT, READY, ISSUED}.
- The package is reused by the FXU and other RS banks.
- Sub-module rr_pick: NRS-bit request vector plus last-grant index in; one-hot grant and valid out. Purely combinational.

## Test plan
- Reset, then dispatch ADD with val0=3 and val1=4 ready → disp_rs_num=0, fxu_valid 2 edges later with op=1, val0=3, val1=4, rs_num=0. A CDB broadcast of tag 0 then frees the entry.
- Dispatch MOV with tag0=9 pending, then cdb(9, 0x1234) → issues with val0=0x1234 one edge after the capture. A CDB broadcast on tag 8 changes nothing.
- Dispatch in the same cycle as cdb(5, 0x00AA) with disp_tag1=5 pending → captured by bypass, entry READY immediately.
- Fill all NRS entries ready with fxu_busy=1 → disp_ready=0 and no issue. Drop busy → issues in order 0,1,2,3, then wraps correctly after the next dispatch to entry 0.
- Entry ISSUED with a CDB broadcast on its own tag while disp_valid=1 → the new dispatch takes a different FREE entry. The released entry is reused on the next cycle.
- Assert reset while entries are in WAIT/READY/ISSUED → all outputs 0 and disp_ready=1 immediately. The next dispatch gets rs_num=RS_BASE.
